// File: rtl/ifu_iccm_arb_if.sv
// ICCM arbiter bus bundle: fetch port, DMA port and ICCM memory port.
//   master : fetch/DMA requesters and the ICCM macro (drive requests,
//            memory read data; observe grants, responses, strobes)
//   slave  : the arbiter itself
// Addresses are word addresses declared [ICCM_BITS-1:2], so index 3 is
// byte-address bit 3 (the 78-bit half-line select).
interface ifu_iccm_arb_if #(
    parameter int ICCM_BITS = 16
);
    logic                  ifu_req;
    logic [ICCM_BITS-1:2]  ifu_addr;
    logic                  ifu_gnt;
    logic                  ifu_flush;
    logic                  ifu_rd_valid;
    logic [155:0]          ifu_rd_data;

    logic                  dma_req;
    logic                  dma_write;
    logic [ICCM_BITS-1:2]  dma_addr;
    logic [2:0]            dma_size;
    logic [77:0]           dma_wdata;
    logic                  dma_gnt;
    logic                  dma_rd_valid;
    logic [77:0]           dma_rd_data;

    logic                  iccm_rden;
    logic                  iccm_wren;
    logic [ICCM_BITS-1:2]  iccm_rw_addr;
    logic [2:0]            iccm_wr_size;
    logic [77:0]           iccm_wr_data;
    logic [155:0]          iccm_rd_data;
    logic                  iccm_busy;

    modport slave (
        input  ifu_req, ifu_addr, ifu_flush,
        input  dma_req, dma_write, dma_addr, dma_size, dma_wdata,
        input  iccm_rd_data,
        output ifu_gnt, ifu_rd_valid, ifu_rd_data,
        output dma_gnt, dma_rd_valid, dma_rd_data,
        output iccm_rden, iccm_wren, iccm_rw_addr, iccm_wr_size,
        output iccm_wr_data, iccm_busy
    );

    modport master (
        output ifu_req, ifu_addr, ifu_flush,
        output dma_req, dma_write, dma_addr, dma_size, dma_wdata,
        output iccm_rd_data,
        input  ifu_gnt, ifu_rd_valid, ifu_rd_data,
        input  dma_gnt, dma_rd_valid, dma_rd_data,
        input  iccm_rden, iccm_wren, iccm_rw_addr, iccm_wr_size,
        input  iccm_wr_data, iccm_busy
    );
endinterface

// File: rtl/ifu_iccm_arb.sv
// ICCM port arbiter between instruction fetch and DMA.
// One grant per cycle, combinational from same-cycle requests; DMA wins
// over fetch. Memory strobes follow the grant combinationally; address,
// write size and write data hold their last granted values. Read data
// returns one cycle after the grant and is steered to the requester by a
// small response FSM (IDLE / FETCH_RSP / DMA_RSP).
// Optional feature: define RV_ICCM_ARB_FAIR_EN to let a waiting fetch
// through after STARVE_MAX consecutive DMA grants.
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : ifu_iccm_arb_if.slave (fetch, DMA and ICCM signals)
module ifu_iccm_arb #(
    parameter int ICCM_BITS  = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    ifu_iccm_arb_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH_RSP = 2'd1,
        DMA_RSP   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  dma_hi_q, dma_hi_d;
    logic [ICCM_BITS-1:2]  addr_q, addr_d;
    logic [2:0]            size_q, size_d;
    logic [77:0]           wdata_q, wdata_d;

    logic                  ifu_gnt, dma_gnt;
    logic                  fair_ifu;

`ifdef RV_ICCM_ARB_FAIR_EN
    localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic [CW-1:0] starve_q, starve_d;

    assign fair_ifu = (starve_q == CW'(STARVE_MAX));

    // Counts DMA wins against a waiting fetch; saturates at STARVE_MAX.
    always_comb begin
        starve_d = starve_q;
        if (!bus.ifu_req || ifu_gnt) begin
            starve_d = '0;
        end else if (dma_gnt && !fair_ifu) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign fair_ifu = 1'b0;
`endif

    // Grants are masked during reset so no strobe escapes while rst=1.
    assign dma_gnt = !rst && bus.dma_req && !(bus.ifu_req && fair_ifu);
    assign ifu_gnt = !rst && bus.ifu_req && !dma_gnt;

    always_comb begin
        state_d        = IDLE;
        dma_hi_d       = dma_hi_q;
        addr_d         = addr_q;
        size_d         = size_q;
        wdata_d        = wdata_q;
        bus.iccm_rden  = 1'b0;
        bus.iccm_wren  = 1'b0;
        if (dma_gnt) begin
            addr_d = bus.dma_addr;
            if (bus.dma_write) begin
                bus.iccm_wren = 1'b1;
                size_d        = bus.dma_size;
                wdata_d       = bus.dma_wdata;
            end else begin
                bus.iccm_rden = 1'b1;
                state_d       = DMA_RSP;
                dma_hi_d      = bus.dma_addr[3];
            end
        end else if (ifu_gnt) begin
            bus.iccm_rden = 1'b1;
            addr_d        = bus.ifu_addr;
            state_d       = FETCH_RSP;
        end
    end

    // Memory-side outputs are the next-state values: live on a grant,
    // otherwise the held register contents.
    assign bus.iccm_rw_addr = addr_d;
    assign bus.iccm_wr_size = size_d;
    assign bus.iccm_wr_data = wdata_d;
    assign bus.ifu_gnt      = ifu_gnt;
    assign bus.dma_gnt      = dma_gnt;

    assign bus.iccm_busy    = (state_q != IDLE);
    assign bus.ifu_rd_valid = (state_q == FETCH_RSP) && !bus.ifu_flush;
    assign bus.ifu_rd_data  = (state_q == FETCH_RSP) ? bus.iccm_rd_data : '0;
    assign bus.dma_rd_valid = (state_q == DMA_RSP);
    assign bus.dma_rd_data  = (state_q != DMA_RSP) ? '0 :
                              dma_hi_q ? bus.iccm_rd_data[155:78]
                                       : bus.iccm_rd_data[77:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            dma_hi_q <= 1'b0;
            addr_q   <= '0;
            size_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            dma_hi_q <= dma_hi_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            wdata_q  <= wdata_d;
        end
    end

endmodule

// File: tb/tb_ifu_iccm_arb.sv
// Directed bench for ifu_iccm_arb with a small 16-line ICCM model.
module tb_ifu_iccm_arb;

    localparam logic [155:0] LINE1 = {78'h11_1111_2222_3333_4444,
                                      78'h00_AAAA_BBBB_CCCC_DDDD};
    localparam logic [77:0]  LOW2  = 78'h05_0505_0606_0707_0808;
    localparam logic [77:0]  WHI   = 78'h2A_DEAD_BEEF_CAFE_F00D;
    localparam logic [77:0]  WLO   = 78'h13_5791_3579_2468_ACE0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    logic [155:0] mem [16];

    ifu_iccm_arb_if #(.ICCM_BITS(16)) bus ();

    ifu_iccm_arb #(.ICCM_BITS(16), .STARVE_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // ICCM model: line = byte address [7:4], half selected by bit 3.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[1] <= LINE1;
            mem[2] <= {78'h0, LOW2};
            bus.iccm_rd_data <= '0;
        end else begin
            if (bus.iccm_wren) begin
                if (bus.iccm_rw_addr[3])
                    mem[bus.iccm_rw_addr[7:4]][155:78] <= bus.iccm_wr_data;
                else
                    mem[bus.iccm_rw_addr[7:4]][77:0] <= bus.iccm_wr_data;
            end
            if (bus.iccm_rden)
                bus.iccm_rd_data <= mem[bus.iccm_rw_addr[7:4]];
        end
    end

    task automatic check(input string tag, input logic [155:0] obs,
                         input logic [155:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic [5:0] pat;
`ifdef RV_ICCM_ARB_FAIR_EN
        pat = 6'b110111;   // cycle 0 is bit 0: DMA DMA DMA FETCH DMA DMA
`else
        pat = 6'b111111;
`endif
        bus.ifu_req   = 1'b1;
        bus.ifu_addr  = 14'h4;
        bus.ifu_flush = 1'b0;
        bus.dma_req   = 1'b1;
        bus.dma_write = 1'b1;
        bus.dma_addr  = 14'hA;
        bus.dma_size  = 3'b011;
        bus.dma_wdata = WHI;

        // Reset: requests present but everything must stay quiet.
        step(); step(); #1;
        check("rst_ifu_gnt", bus.ifu_gnt, 0);
        check("rst_dma_gnt", bus.dma_gnt, 0);
        check("rst_rden", bus.iccm_rden, 0);
        check("rst_wren", bus.iccm_wren, 0);
        check("rst_busy", bus.iccm_busy, 0);
        check("rst_addr", bus.iccm_rw_addr, 0);
        check("rst_wdata", bus.iccm_wr_data, 0);
        check("rst_ifu_valid", bus.ifu_rd_valid, 0);

        step();
        rst = 1'b0; bus.ifu_req = 1'b0; bus.dma_req = 1'b0;

        // Single fetch at byte 0x10.
        step(); bus.ifu_req = 1'b1; bus.ifu_addr = 14'h4; #1;
        check("fetch_gnt", bus.ifu_gnt, 1);
        check("fetch_rden", bus.iccm_rden, 1);
        check("fetch_addr", bus.iccm_rw_addr, 14'h4);
        check("fetch_no_dma", bus.dma_gnt, 0);
        step(); bus.ifu_req = 1'b0; #1;
        check("fetch_valid", bus.ifu_rd_valid, 1);
        check("fetch_data", bus.ifu_rd_data, LINE1);
        check("fetch_busy", bus.iccm_busy, 1);
        check("fetch_addr_hold", bus.iccm_rw_addr, 14'h4);
        step(); #1;
        check("fetch_idle_busy", bus.iccm_busy, 0);
        check("fetch_idle_valid", bus.ifu_rd_valid, 0);

        // DMA dword write to byte 0x28 (line 0x20, upper half), read back.
        step();
        bus.dma_req = 1'b1; bus.dma_write = 1'b1; bus.dma_addr = 14'hA;
        bus.dma_size = 3'b011; bus.dma_wdata = WHI; #1;
        check("dwr_gnt", bus.dma_gnt, 1);
        check("dwr_wren", bus.iccm_wren, 1);
        check("dwr_rden", bus.iccm_rden, 0);
        check("dwr_addr", bus.iccm_rw_addr, 14'hA);
        check("dwr_size", bus.iccm_wr_size, 3'b011);
        check("dwr_data", bus.iccm_wr_data, WHI);
        step(); bus.dma_write = 1'b0; #1;
        check("drd_gnt", bus.dma_gnt, 1);
        check("drd_rden", bus.iccm_rden, 1);
        check("drd_wren", bus.iccm_wren, 0);
        check("drd_busy_after_wr", bus.iccm_busy, 0);
        check("drd_wdata_hold", bus.iccm_wr_data, WHI);
        step(); bus.dma_addr = 14'h8; #1;
        check("drd_hi_valid", bus.dma_rd_valid, 1);
        check("drd_hi_data", bus.dma_rd_data, WHI);
        step(); bus.dma_write = 1'b1; bus.dma_size = 3'b100; bus.dma_wdata = WLO; #1;
        check("drd_lo_valid", bus.dma_rd_valid, 1);
        check("drd_lo_data", bus.dma_rd_data, LOW2);
        check("dwr2_wren", bus.iccm_wren, 1);
        check("dwr2_size", bus.iccm_wr_size, 3'b100);
        step(); bus.dma_write = 1'b0; #1;
        check("dwr2_no_valid", bus.dma_rd_valid, 0);
        check("drd2_rden", bus.iccm_rden, 1);
        step(); bus.dma_req = 1'b0; #1;
        check("drd2_valid", bus.dma_rd_valid, 1);
        check("drd2_data", bus.dma_rd_data, WLO);
        check("drd2_busy", bus.iccm_busy, 1);
        check("idle_rden", bus.iccm_rden, 0);
        check("idle_addr_hold", bus.iccm_rw_addr, 14'h8);

        // Collision: both request for six cycles.
        step();
        bus.dma_addr = 14'hA; bus.ifu_addr = 14'h4;
        bus.dma_req = 1'b1; bus.ifu_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            #1;
            check($sformatf("coll_dma_gnt%0d", i), bus.dma_gnt, pat[i]);
            check($sformatf("coll_ifu_gnt%0d", i), bus.ifu_gnt, !pat[i]);
        end
        step(); bus.dma_req = 1'b0; bus.ifu_req = 1'b0;
        step();

        // Fetch followed by a flush in its response cycle.
        step(); bus.ifu_req = 1'b1; #1;
        check("flush_gnt", bus.ifu_gnt, 1);
        step(); bus.ifu_req = 1'b0; bus.ifu_flush = 1'b1; #1;
        check("flush_valid", bus.ifu_rd_valid, 0);
        check("flush_busy", bus.iccm_busy, 1);
        step(); bus.ifu_flush = 1'b0;

        // Reset pulsed during the fetch response cycle.
        step(); bus.ifu_req = 1'b1; #1;
        check("rstmid_gnt", bus.ifu_gnt, 1);
        step(); bus.ifu_req = 1'b0; rst = 1'b1; #1;
        check("rstmid_valid", bus.ifu_rd_valid, 0);
        check("rstmid_busy", bus.iccm_busy, 0);
        check("rstmid_data", bus.ifu_rd_data, 0);
        step(); rst = 1'b0; bus.ifu_req = 1'b1; #1;
        check("rstrel_valid", bus.ifu_rd_valid, 0);
        check("rstrel_gnt", bus.ifu_gnt, 1);
        step(); bus.ifu_req = 1'b0; #1;
        check("rstrel_rsp_valid", bus.ifu_rd_valid, 1);
        check("rstrel_rsp_data", bus.ifu_rd_data, LINE1);

        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
